multicycle_adder: RTL
=====================

// Module: multicycle_adder
// PURPOSE
//  Parametrised multi-cycle add/subtract unit for the lab datapath.
//  Adds two WIDTH-bit operands CHUNK bits per clock, over NCHUNK = WIDTH/CHUNK cycles.
//  Uses a start/busy/done handshake and provides carry-out and signed-overflow flags.
//  Trades latency for area against the single-cycle ripple adder; sits between operand regs and ALU result mux.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 1
//  CHUNK   4  bits added per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0 (else elaboration error)
// PORTS
//  clk       in   1      rising-edge clock, the only clock
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only when busy==0
//  op_sub    in   1      0: a+b+cin, 1: a-b (a + ~b + 1; cin ignored)
//  a         in   WIDTH  operand A, captured on accepted start
//  b         in   WIDTH  operand B, captured on accepted start
//  cin       in   1      carry-in for add, captured on accepted start
//  busy      out  1      high while the operation is in progress (RUN)
//  done      out  1      one-cycle pulse: sum/cout/ovf valid
//  sum       out  WIDTH  result, held until next accepted start completes
//  cout      out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf       out  1      two's-complement overflow of the MSB chunk
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; idx=0; operand regs=0.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: start=1 at edge -> latch a, b^{WIDTH{op_sub}}, carry=op_sub?1:cin; idx=0; go RUN.
//    RUN:  each edge adds chunk idx (bits idx*CHUNK +: CHUNK) with the carry reg.
//          Writes that chunk of the sum reg and updates the carry reg; idx++.
//          At idx==NCHUNK-1: write cout/ovf, go DONE.
//    DONE: done=1 for exactly one cycle; start here is accepted as in IDLE (back-to-back); else go IDLE.
//  - Latency: start accepted at edge E -> busy=1 for cycles after E..E+NCHUNK-1; done=1 in cycle after E+NCHUNK.
//  - busy is a registered state decode (RUN); done is a registered state decode (DONE); no comb path from inputs.
//  - start while busy=1: ignored, no effect on operands or state.
//  - sum/cout/ovf: update only at completion.
//    Bits of sum being rewritten during RUN are not valid until done; consumers sample on done only.
//  - ovf = carry into MSB XOR carry out of MSB (from the final chunk).
//  - NCHUNK==1 (CHUNK==WIDTH): RUN lasts one cycle; done one cycle later.
//  - Reset mid-RUN: immediate abort to reset values; no done pulse; next start behaves normally.
//  - Inputs a/b/cin/op_sub may change freely after the accepting edge.
// STRUCTURE
//  - Package adder_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//    Also the clog2-based index width function shared with other multi-cycle units.
//  - Sub-module fa_chunk #(CHUNK): combinational CHUNK-bit ripple of full-adder cells.
//    Inputs: x, y, ci. Outputs: s, co, c_msb_in (carry into top bit, for ovf).
//  - Top: FSM, idx counter, operand/carry/sum regs, chunk mux; one fa_chunk instance.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//  1. a=16'h00FF, b=16'h0001, cin=0, add
//     -> busy high 4 cycles, done 5th cycle; sum=16'h0100, cout=0, ovf=0.
//  2. a=16'hFFFF, b=16'h0001, cin=0, add -> sum=16'h0000, cout=1, ovf=0.
//     Then a=16'h7FFF, b=16'h0000, cin=1 -> sum=16'h8000, cout=0, ovf=1.
//  3. op_sub, a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
//     Then a=16'h0003, b=16'h0005 -> sum=16'hFFFE, cout=0, ovf=0.
//  4. Second start (different a/b) pulsed on the 2nd busy cycle -> ignored; result is of the first op.
//     A start during the done cycle -> accepted, second result correct, done pulses again 5 cycles later.
//  5. rst_n low for 1 cycle mid-RUN -> all outputs 0 immediately, no done.
//     New start afterwards, 16'h1234+16'h4321 -> 16'h5555.
//  6. Sweep CHUNK=1,4,16 with 1000 random a/b/cin/op_sub vs reference model.
//     Check sum/cout/ovf and that done comes exactly NCHUNK+1 cycles after start.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle arithmetic units: FSM encoding and
// the counter-width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter that indexes n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also
// exposes the carry into the top bit so the caller can derive overflow.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
    assign w_c[gi+1] = (x[gi] & y[gi]) | (x[gi] & w_c[gi]) | (y[gi] & w_c[gi]);
  end

  assign co       = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract: processes CHUNK bits per clock through a single
// fa_chunk instance, with a start/busy/done handshake and carry/overflow flags.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a, r_b, r_acc, r_sum;
  logic               r_carry, r_cout, r_ovf;

  logic [CHUNK-1:0]   w_x, w_y, w_s;
  logic               w_co, w_cmsb;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_accept, w_last;

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));

  // Select the active chunk and splice the new partial sum into the work copy.
  always_comb begin
    w_x        = '0;
    w_y        = '0;
    w_acc_next = r_acc;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_x                          = r_a[i*CHUNK +: CHUNK];
        w_y                          = r_b[i*CHUNK +: CHUNK];
        w_acc_next[i*CHUNK +: CHUNK] = w_s;
      end
    end
  end

  fa_chunk #(.CHUNK(CHUNK)) u_fa_chunk (
    .x        (w_x),
    .y        (w_y),
    .ci       (r_carry),
    .s        (w_s),
    .co       (w_co),
    .c_msb_in (w_cmsb)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // The work copy r_acc absorbs intermediate chunks so the visible result
  // only changes when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_a     <= a;
      r_b     <= b ^ {WIDTH{op_sub}};
      r_carry <= op_sub ? 1'b1 : cin;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_co;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_co;
        r_ovf  <= w_co ^ w_cmsb;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
